// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin values, change codes,
// dispenser states and the change-code decoder.
package change_dispenser_pkg;

  localparam logic [4:0] NICKLE     = 5'd5;
  localparam logic [4:0] DIME       = 5'd10;
  localparam logic [4:0] SODA_PRICE = 5'd20;

  typedef enum logic [2:0] {
    CHG_0  = 3'b000,
    CHG_10 = 3'b001,
    CHG_15 = 3'b010,
    CHG_20 = 3'b011,
    CHG_25 = 3'b100
  } change_code_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_VEND    = 3'd2,
    S_GAP     = 3'd3,
    S_EJECT   = 3'd4
  } disp_state_e;

  typedef enum logic {
    COIN_NICKLE = 1'b0,
    COIN_DIME   = 1'b1
  } coin_e;

  function automatic logic code_valid(input logic [2:0] code);
    return (code <= CHG_25);
  endfunction

  // Invalid codes decode to zero cents; the caller raises the fault.
  function automatic logic [4:0] decode_change(input logic [2:0] code);
    logic [4:0] cents;
    case (code)
      CHG_10:  cents = DIME;
      CHG_15:  cents = DIME + NICKLE;
      CHG_20:  cents = DIME + DIME;
      CHG_25:  cents = DIME + DIME + NICKLE;
      default: cents = 5'd0;
    endcase
    return cents;
  endfunction

endpackage

// File: rtl/change_dispenser_pulse_timer.sv
// Down-counter shared by every timed phase of the dispenser; load N-1 to
// get an N-cycle phase, done is high while the count is zero.
module pulse_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         count_i,
  output logic         done_o
);

  logic [W-1:0] cnt_d, cnt_q;

  // Next count: load wins, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (count_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Turns the vending FSM's soda strobe and change code into timed vend and
// coin-eject pulses, substituting nickels for an empty dime tube.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned CAPTURE_CYCLES = 2,
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned GAP_CYCLES     = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       soda_i,
  input  logic [2:0] change_i,
  input  logic       dime_empty_i,
  input  logic       nickle_empty_i,
  output logic       vend_o,
  output logic       eject_dime_o,
  output logic       eject_nickle_o,
  output logic       busy_o,
  output logic       fault_o
);

  localparam int unsigned MAX_A   = (CAPTURE_CYCLES > PULSE_CYCLES) ? CAPTURE_CYCLES : PULSE_CYCLES;
  localparam int unsigned MAX_P   = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int unsigned TIMER_W = $clog2(MAX_P) + 1;

  localparam logic [TIMER_W-1:0] CAPTURE_LOAD = TIMER_W'(CAPTURE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] PULSE_LOAD   = TIMER_W'(PULSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD     = TIMER_W'(GAP_CYCLES - 1);

  disp_state_e  state_d, state_q;
  coin_e        coin_d, coin_q;
  logic [2:0]   code_d, code_q;
  logic [2:0]   chg_prev_d, chg_prev_q;
  logic [4:0]   rem_d, rem_q;
  logic         soda_d, soda_q;
  logic         soda_evt_d, soda_evt_q;
  logic         fault_d, fault_q;
  logic         vend_d, vend_q;
  logic         dime_d, dime_q;
  logic         nick_d, nick_q;
  logic         busy_d, busy_q;

  logic                 soda_rise_s;
  logic                 event_s;
  logic [2:0]           code_eff_s;
  logic                 tmr_load_s;
  logic [TIMER_W-1:0]   tmr_val_s;
  logic                 tmr_done_s;

  pulse_timer #(.W(TIMER_W)) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .count_i    (state_q != S_IDLE),
    .done_o     (tmr_done_s)
  );

  // Request detection and the code as seen this cycle; edge regs always track inputs.
  always_comb begin
    soda_rise_s = soda_i & ~soda_q;
    event_s     = soda_rise_s | ((chg_prev_q == 3'b000) & (change_i != 3'b000));
    code_eff_s  = (change_i != 3'b000) ? change_i : code_q;
    soda_d      = soda_i;
    chg_prev_d  = change_i;
  end

  // Sequencing FSM; outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    state_d    = state_q;
    coin_d     = coin_q;
    code_d     = code_q;
    rem_d      = rem_q;
    soda_evt_d = soda_evt_q;
    fault_d    = fault_q;
    tmr_load_s = 1'b0;
    tmr_val_s  = '0;
    case (state_q)
      S_IDLE: begin
        if (event_s) begin
          state_d    = S_CAPTURE;
          code_d     = change_i;
          soda_evt_d = soda_rise_s;
          tmr_load_s = 1'b1;
          tmr_val_s  = CAPTURE_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CAPTURE: begin
        code_d = code_eff_s;
        if (tmr_done_s) begin
          rem_d      = decode_change(code_eff_s);
          fault_d    = fault_q | ~code_valid(code_eff_s);
          tmr_load_s = 1'b1;
          if (soda_evt_q) begin
            state_d   = S_VEND;
            tmr_val_s = PULSE_LOAD;
          end else begin
            state_d   = S_GAP;
            tmr_val_s = GAP_LOAD;
          end
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_VEND: begin
        if (tmr_done_s) begin
          state_d    = S_GAP;
          tmr_load_s = 1'b1;
          tmr_val_s  = GAP_LOAD;
        end else begin
          state_d = S_VEND;
        end
      end
      S_GAP: begin
        if (!tmr_done_s) begin
          state_d = S_GAP;
        end else if (rem_q == 5'd0) begin
          state_d = S_IDLE;
        end else if ((rem_q >= DIME) && !dime_empty_i) begin
          state_d    = S_EJECT;
          coin_d     = COIN_DIME;
          tmr_load_s = 1'b1;
          tmr_val_s  = PULSE_LOAD;
        end else if ((rem_q >= NICKLE) && !nickle_empty_i) begin
          state_d    = S_EJECT;
          coin_d     = COIN_NICKLE;
          tmr_load_s = 1'b1;
          tmr_val_s  = PULSE_LOAD;
        end else begin
          // Owed change cannot be paid from what is left in the tubes.
          state_d = S_IDLE;
          fault_d = 1'b1;
          rem_d   = 5'd0;
        end
      end
      S_EJECT: begin
        if (tmr_done_s) begin
          rem_d      = rem_q - ((coin_q == COIN_DIME) ? DIME : NICKLE);
          state_d    = S_GAP;
          tmr_load_s = 1'b1;
          tmr_val_s  = GAP_LOAD;
        end else begin
          state_d = S_EJECT;
        end
      end
      default: begin
        state_d = S_IDLE;
        rem_d   = 5'd0;
      end
    endcase
    vend_d = (state_d == S_VEND);
    dime_d = (state_d == S_EJECT) && (coin_d == COIN_DIME);
    nick_d = (state_d == S_EJECT) && (coin_d == COIN_NICKLE);
    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      coin_q     <= COIN_NICKLE;
      code_q     <= 3'b000;
      chg_prev_q <= 3'b000;
      rem_q      <= 5'd0;
      soda_q     <= 1'b0;
      soda_evt_q <= 1'b0;
      fault_q    <= 1'b0;
      vend_q     <= 1'b0;
      dime_q     <= 1'b0;
      nick_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      coin_q     <= coin_d;
      code_q     <= code_d;
      chg_prev_q <= chg_prev_d;
      rem_q      <= rem_d;
      soda_q     <= soda_d;
      soda_evt_q <= soda_evt_d;
      fault_q    <= fault_d;
      vend_q     <= vend_d;
      dime_q     <= dime_d;
      nick_q     <= nick_d;
      busy_q     <= busy_d;
    end
  end

  assign vend_o         = vend_q;
  assign eject_dime_o   = dime_q;
  assign eject_nickle_o = nick_q;
  assign busy_o         = busy_q;
  assign fault_o        = fault_q;

endmodule
